mem_stream_ctrl: RTL and testbench
==================================

# mem_stream_ctrl

Streaming front-end that sits directly upstream of `syn_mem` and owns its write-enable, write-data and address pins. It packs an incoming valid/ready word stream into consecutive memory addresses starting at 0. On request, it replays the stored words in address order as a valid-qualified output stream. It also accounts for the memory's one-cycle registered read latency.

## Interface
- `ADDR_SIZE`, 4, memory address width; depth = 2^ADDR_SIZE words
- `WORD_SIZE`, 8, data word width
- `I_clk`  in  1  clock, all logic on rising edge
- `I_rst`  in  1  asynchronous, active-high reset
- `I_wr_valid`  in  1  upstream word valid
- `I_wr_data`  in  WORD_SIZE  upstream word
- `O_wr_ready`  out  1  block accepts a word this cycle
- `I_clear`  in  1  discard stored contents (count to 0), honoured in IDLE only
- `I_rd_start`  in  1  start replay of all stored words, honoured in IDLE only
- `O_rd_valid`  out  1  `O_rd_data` is a replayed word
- `O_rd_data`  out  WORD_SIZE  replayed word
- `O_busy`  out  1  replay in progress (READ or DRAIN)
- `O_count`  out  ADDR_SIZE+1  number of stored words, 0..2^ADDR_SIZE
- `O_full`  out  1  `O_count == 2^ADDR_SIZE`
- `O_mem_wen`  out  1  to `syn_mem` `I_wen`
- `O_mem_wdata`  out  WORD_SIZE  to `syn_mem` `I_wdata`
- `O_mem_addr`  out  ADDR_SIZE  to `syn_mem` `I_addr`
- `I_mem_rdata`  in  WORD_SIZE  from `syn_mem` `O_data`; valid one cycle after address is presented

## Operation
- **States:** IDLE, READ, DRAIN. Internal registers: `count` (ADDR_SIZE+1 bits), `rd_ptr` (ADDR_SIZE+1 bits), `rd_len`, `rd_valid_q`.
- **Write path:** combinational.
  - `O_wr_ready = (state==IDLE) & !O_full & !I_rst`.
  - `O_mem_wen = I_wr_valid & O_wr_ready`.
  - `O_mem_wdata = I_wr_data`.
  - In IDLE, `O_mem_addr = count[ADDR_SIZE-1:0]`.
  - An accepted word increments `count` at the edge.
- **Clear:** `I_clear` in IDLE sets `count` to 0.
  - If a write occurs in the same cycle, clear takes priority for the address: the word is written to address 0 and `count` becomes 1.
- **Full:** when `count == 2^ADDR_SIZE`, `O_wr_ready` is 0 and `I_wr_valid` is ignored. There is no wrap-around and no overwrite.
- **IDLE → READ:** taken when `I_rd_start=1` and the post-edge count is nonzero.
  - `rd_len` captures the count including any word written in that same cycle.
  - `rd_ptr` is set to 0.
  - `I_rd_start` with a post-edge count of 0 is ignored and the state stays IDLE.
  - `I_clear` and `I_rd_start` together: clear applies first, so the start is ignored unless a write lands in that cycle, in which case `rd_len = 1`.
- **READ:**
  - `O_mem_addr = rd_ptr[ADDR_SIZE-1:0]` and `O_mem_wen = 0`.
  - `rd_ptr` increments each cycle.
  - When `rd_ptr == rd_len-1`, go to DRAIN.
- **DRAIN:** one cycle, then IDLE. `O_mem_addr` holds the last read address.
- **Read data path:**
  - `rd_valid_q <= (state==READ)`.
  - `O_rd_valid = rd_valid_q`.
  - `O_rd_data = I_mem_rdata` (pass-through).
- **Inputs ignored outside IDLE:** `I_clear` and `I_rd_start` are ignored in READ and DRAIN.
- **Stored words are preserved:** `count` is unchanged by a replay, so a replay can be repeated.
- **Reset values:**
  - Registers: state=IDLE, `count`=0, `rd_ptr`=0, `rd_len`=0, `rd_valid_q`=0.
  - Outputs: `O_rd_valid`=0, `O_busy`=0, `O_count`=0, `O_full`=0, `O_mem_wen`=0, `O_wr_ready`=0 while `I_rst` is high.
  - `O_mem_addr`=0 in IDLE with `count` at 0.
- **Reset mid-replay:** an asynchronous abort. Outputs fall immediately, no further `O_rd_valid` is produced, and stored contents are considered lost (`count`=0).

## Timing
- **Write throughput:** one word per cycle. Zero-latency pass-through to memory; the word lands at the same edge that increments `count`.
- **Replay of N words with `I_rd_start` sampled at edge k:**
  - READ occupies cycles k+1..k+N.
  - DRAIN occupies cycle k+N+1.
  - IDLE resumes at k+N+2.
  - `O_rd_valid` is high in cycles k+2..k+N+1, carrying addresses 0..N-1 in order with no gaps.
- **`O_busy`** is high in cycles k+1..k+N+1.
- **`O_wr_ready`** is 0 from k+1 through k+N+1 and returns at k+N+2 if not full.
- **Back-to-back replay:** `I_rd_start` in the first IDLE cycle after DRAIN starts the next replay. Minimum gap between replays is 1 IDLE cycle.

## Test plan
- **Reset check:** assert `I_rst` mid-cycle → all outputs at reset values without waiting for a clock edge.
- **Write then replay:** reset, then stream 10 words 1..10 with `I_wr_valid` held high → `O_count`=10, memory addresses 0..9 hold 1..10. Pulse `I_rd_start` → `O_rd_valid` high for exactly 10 consecutive cycles starting 2 cycles after the start edge, data 1..10, `O_busy` high for 11 cycles.
- **Fill to full:** write 16 words with `ADDR_SIZE`=4 → `O_full`=1, `O_wr_ready`=0. A 17th word is held off with `O_mem_wen`=0, and address 0 still holds the first word on replay.
- **Empty and clear/start interactions:**
  - `I_rd_start` with `count`=0 → stays IDLE, `O_busy`=0, no `O_rd_valid`.
  - `I_clear` + `I_wr_valid` (data 0xA5) in one cycle → `O_count`=1; replay yields the single word 0xA5.
  - Write and `I_rd_start` in the same cycle after 3 stored words → replay of 4 words.
- **Inputs during replay:** `I_wr_valid`, `I_clear` and `I_rd_start` asserted during READ → no write, `count` unchanged, replay completes intact.
- **Reset mid-replay:** assert `I_rst` in the 3rd READ cycle → `O_rd_valid` drops immediately, state IDLE, `O_count`=0 after release.

Source files
------------

// File: rtl/mem_stream_ctrl.sv
// mem_stream_ctrl: packs a valid/ready word stream into syn_mem from address 0
// and replays the stored words in address order as a valid-qualified stream,
// absorbing the memory's one-cycle registered read latency.
module mem_stream_ctrl #(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned WORD_SIZE = 8
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_wr_valid,
    input  logic [WORD_SIZE-1:0] I_wr_data,
    output logic                 O_wr_ready,
    input  logic                 I_clear,
    input  logic                 I_rd_start,
    output logic                 O_rd_valid,
    output logic [WORD_SIZE-1:0] O_rd_data,
    output logic                 O_busy,
    output logic [ADDR_SIZE:0]   O_count,
    output logic                 O_full,
    output logic                 O_mem_wen,
    output logic [WORD_SIZE-1:0] O_mem_wdata,
    output logic [ADDR_SIZE-1:0] O_mem_addr,
    input  logic [WORD_SIZE-1:0] I_mem_rdata
);

    localparam int unsigned CW    = ADDR_SIZE + 1;
    localparam int unsigned DEPTH = 1 << ADDR_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   rd_ptr;
    logic [CW-1:0]   rd_len;
    logic            rd_valid_q;

    logic            clear_c;
    logic            wr_acc_c;
    logic [CW-1:0]   base_count_c;
    logic [CW-1:0]   next_count_c;

    // Write handshake, memory pin muxing and status outputs
    always_comb begin
        O_full       = (count == CW'(DEPTH));
        O_wr_ready   = (state == IDLE) & ~O_full & ~I_rst;
        wr_acc_c     = I_wr_valid & O_wr_ready;
        clear_c      = (state == IDLE) & I_clear;
        // A clear in the same cycle as a write redirects that word to address 0
        base_count_c = clear_c ? '0 : count;
        next_count_c = base_count_c + CW'(wr_acc_c);

        O_mem_wen    = wr_acc_c;
        O_mem_wdata  = I_wr_data;
        O_mem_addr   = rd_ptr[ADDR_SIZE-1:0];
        if (state == IDLE) begin
            O_mem_addr = base_count_c[ADDR_SIZE-1:0];
        end

        O_busy       = (state != IDLE);
        O_rd_valid   = rd_valid_q;
        O_rd_data    = I_mem_rdata;
        O_count      = count;
    end

    // Replay FSM with word count and read pointer; reset aborts any replay
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state      <= IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            rd_len     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            // Memory data for the address presented in READ appears one cycle later
            rd_valid_q <= (state == READ);
            case (state)
                IDLE: begin
                    count <= next_count_c;
                    if (I_rd_start && (next_count_c != '0)) begin
                        state  <= READ;
                        rd_len <= next_count_c;
                        rd_ptr <= '0;
                    end
                end
                READ: begin
                    // Pointer stays on the last address so DRAIN keeps presenting it
                    if (rd_ptr == (rd_len - CW'(1))) begin
                        state <= DRAIN;
                    end else begin
                        rd_ptr <= rd_ptr + CW'(1);
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Self-checking bench for mem_stream_ctrl with a behavioural syn_mem model and
// a scoreboard queue of expected replay words.
module tb_mem_stream_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       clear;
    logic       rd_start;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic [4:0] count;
    logic       full;
    logic       mem_wen;
    logic [7:0] mem_wdata;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata;

    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    int         ref_count;
    logic [7:0] exp_q [$];

    int n_checks;
    int n_pass;

    mem_stream_ctrl #(.ADDR_SIZE(4), .WORD_SIZE(8)) dut (
        .I_clk       (clk),
        .I_rst       (rst),
        .I_wr_valid  (wr_valid),
        .I_wr_data   (wr_data),
        .O_wr_ready  (wr_ready),
        .I_clear     (clear),
        .I_rd_start  (rd_start),
        .O_rd_valid  (rd_valid),
        .O_rd_data   (rd_data),
        .O_busy      (busy),
        .O_count     (count),
        .O_full      (full),
        .O_mem_wen   (mem_wen),
        .O_mem_wdata (mem_wdata),
        .O_mem_addr  (mem_addr),
        .I_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // syn_mem model: synchronous write, registered read
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Replay monitor: every valid word must match the head of the scoreboard
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) check("rd_extra", 32'(rd_valid), 32'd0);
            else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word (optionally with clear) for one cycle and track the model
    task automatic write_word(input logic [7:0] d, input bit clr);
        bit ready_exp;
        int idx;
        wr_valid = 1'b1;
        wr_data  = d;
        clear    = clr;
        #1;
        ready_exp = (ref_count < 16);
        idx = clr ? 0 : ref_count;
        check("wr_ready", 32'(wr_ready), 32'(ready_exp));
        check("wen", 32'(mem_wen), 32'(ready_exp));
        if (ready_exp) check("waddr", 32'(mem_addr), 32'(idx));
        tick();
        if (clr) ref_count = 0;
        if (ready_exp) begin
            ref_mem[idx] = d;
            ref_count = idx + 1;
        end
        wr_valid = 1'b0;
        clear    = 1'b0;
        check("count", 32'(count), 32'(ref_count));
        check("full", 32'(full), 32'(ref_count == 16));
    endtask

    // Cycle-by-cycle checks after the start edge k; entered at cycle k+1
    task automatic replay_check(input int n, input bit noisy);
        for (int i = 1; i <= n + 2; i++) begin
            wr_valid = noisy && (i <= n + 1);
            clear    = noisy && (i <= n + 1);
            rd_start = noisy && (i <= n + 1);
            wr_data  = 8'hEE;
            #1;
            check("busy", 32'(busy), 32'(i <= n + 1));
            check("rd_valid", 32'(rd_valid), 32'(i >= 2 && i <= n + 1));
            check("wen_rd", 32'(mem_wen), 32'd0);
            check("count_rd", 32'(count), 32'(ref_count));
            if (i <= n) check("raddr", 32'(mem_addr), 32'(i - 1));
            else if (i == n + 1) check("drain_addr", 32'(mem_addr), 32'(n - 1));
            if (i == n + 2) check("ready_after", 32'(wr_ready), 32'(ref_count < 16));
            else check("ready_rd", 32'(wr_ready), 32'd0);
            if (i < n + 2) tick();
        end
        check("q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[i]);
    endtask

    task automatic replay(input int n, input bit noisy);
        push_expected(n);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        replay_check(n, noisy);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        ref_count = 0;
        rst       = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        clear     = 1'b0;
        rd_start  = 1'b0;

        // Reset asserted between edges takes effect immediately
        #1 rst = 1'b1;
        #1;
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(wr_ready), 32'd1);

        // Stream 1..10 then replay
        for (int i = 1; i <= 10; i++) write_word(8'(i), 1'b0);
        replay(10, 1'b0);

        // Fill to full, 17th word held off, replay twice back-to-back
        for (int i = 11; i <= 16; i++) write_word(8'(i), 1'b0);
        write_word(8'hEE, 1'b0);
        replay(16, 1'b0);
        replay(16, 1'b0);

        // Clear, then start with nothing stored is ignored
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ref_count = 0;
        check("clear_count", 32'(count), 32'd0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("empty_busy", 32'(busy), 32'd0);
            check("empty_ready", 32'(wr_ready), 32'd1);
            tick();
        end

        // Clear plus write in one cycle keeps only the new word
        write_word(8'h11, 1'b0);
        write_word(8'hA5, 1'b1);
        replay(1, 1'b0);

        // Three stored words, fourth written in the start cycle
        write_word(8'h30, 1'b1);
        write_word(8'h31, 1'b0);
        write_word(8'h32, 1'b0);
        rd_start = 1'b1;
        write_word(8'h33, 1'b0);
        rd_start = 1'b0;
        push_expected(4);
        replay_check(4, 1'b0);

        // Inputs toggled during replay are ignored
        replay(4, 1'b1);

        // Reset in the third READ cycle aborts the replay
        push_expected(4);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        wr_valid = 1'b1;
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        ref_count = 0;
        check("abort_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        check("abort_ready", 32'(wr_ready), 32'd0);
        check("abort_wen", 32'(mem_wen), 32'd0);
        wr_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_ready", 32'(wr_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Recovery after abort
        write_word(8'h5A, 1'b0);
        write_word(8'hC3, 1'b0);
        replay(2, 1'b0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
